// File: rtl/nn_pkg.sv
// Shared fixed-point datapath defaults and FSM state type for the NN post-processing blocks.
package nn_pkg;

    localparam int NN_DIM     = 8;
    localparam int NN_NUM_BIT = 16;
    localparam int NN_FRAC    = 8;

    typedef logic signed [NN_NUM_BIT-1:0] fx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FINAL = 2'd2,
        ST_OUT   = 2'd3
    } acc_state_e;

endpackage

// File: rtl/acc_lane.sv
// One lane of acc_act: bias-loaded accumulator, optional ReLU (ACC_RELU_EN) and signed saturation
// into a registered NUM_BIT result.
module acc_lane
    import nn_pkg::*;
#(
    parameter int NUM_BIT = NN_NUM_BIT,
    parameter int ACC_BIT = NN_NUM_BIT + 3
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               add,
    input  logic               capture,
    input  logic [NUM_BIT-1:0] bias,
    input  logic [NUM_BIT-1:0] wx,
    output logic [NUM_BIT-1:0] y
);

    localparam logic signed [ACC_BIT-1:0] SAT_MAX =
        {{(ACC_BIT-NUM_BIT+1){1'b0}}, {(NUM_BIT-1){1'b1}}};
    localparam logic signed [ACC_BIT-1:0] SAT_MIN =
        {{(ACC_BIT-NUM_BIT+1){1'b1}}, {(NUM_BIT-1){1'b0}}};

    logic signed [ACC_BIT-1:0] acc_q;
    logic signed [ACC_BIT-1:0] bias_ext;
    logic signed [ACC_BIT-1:0] wx_ext;
    logic signed [ACC_BIT-1:0] act_v;
    logic        [NUM_BIT-1:0] y_sat;
    logic        [NUM_BIT-1:0] y_q;

    assign bias_ext = {{(ACC_BIT-NUM_BIT){bias[NUM_BIT-1]}}, bias};
    assign wx_ext   = {{(ACC_BIT-NUM_BIT){wx[NUM_BIT-1]}}, wx};

    always_comb begin
        act_v = acc_q;
`ifdef ACC_RELU_EN
        if (acc_q < 0) begin
            act_v = '0;
        end
`endif
        y_sat = act_v[NUM_BIT-1:0];
        if (act_v > SAT_MAX) begin
            y_sat = SAT_MAX[NUM_BIT-1:0];
        end else if (act_v < SAT_MIN) begin
            y_sat = SAT_MIN[NUM_BIT-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            if (load) begin
                acc_q <= bias_ext;
            end else if (add) begin
                acc_q <= acc_q + wx_ext;
            end
            if (capture) begin
                y_q <= y_sat;
            end
        end
    end

    assign y = y_q;

endmodule

// File: rtl/acc_act.sv
// Post-MVM accumulate/bias/activation stage: sums NUM_PASS partial vectors plus bias, saturates,
// and hands the result downstream over valid/ready. ReLU is enabled by defining ACC_RELU_EN.
module acc_act
    import nn_pkg::*;
#(
    parameter int DIM      = NN_DIM,
    parameter int NUM_BIT  = NN_NUM_BIT,
    parameter int FRAC     = NN_FRAC,
    parameter int NUM_PASS = 4,
    parameter int ACC_BIT  = NUM_BIT + $clog2(NUM_PASS) + 1
)(
    input  logic                          i_clk_acc,
    input  logic                          i_rst_acc,
    input  logic                          i_start_acc,
    input  logic [DIM-1:0][NUM_BIT-1:0]   i_bias_acc,
    input  logic                          i_wx_valid,
    input  logic [DIM-1:0][NUM_BIT-1:0]   i_wx_result,
    output logic                          o_busy,
    output logic                          o_drop,
    output logic                          o_y_valid,
    input  logic                          i_y_ready,
    output logic [DIM-1:0][NUM_BIT-1:0]   o_y_result
);

    localparam int CNT_W = $clog2(NUM_PASS + 1);

    if (NUM_PASS < 1 || FRAC >= NUM_BIT) begin : g_param_check
        $error("acc_act: NUM_PASS must be >= 1 and FRAC < NUM_BIT");
    end

    acc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;
    logic             lane_load, lane_add, lane_final;

    always_ff @(posedge i_clk_acc) begin
        if (i_rst_acc) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // Start overrides every state, including a pending or simultaneously accepted OUT vector.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drop_d     = 1'b0;
        lane_load  = 1'b0;
        lane_add   = 1'b0;
        lane_final = 1'b0;
        if (i_start_acc) begin
            state_d   = ST_ACCUM;
            cnt_d     = '0;
            lane_load = 1'b1;
            drop_d    = i_wx_valid;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    drop_d = i_wx_valid;
                end
                ST_ACCUM: begin
                    if (i_wx_valid) begin
                        lane_add = 1'b1;
                        cnt_d    = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(NUM_PASS - 1)) begin
                            state_d = ST_FINAL;
                        end
                    end
                end
                ST_FINAL: begin
                    lane_final = 1'b1;
                    drop_d     = i_wx_valid;
                    state_d    = ST_OUT;
                end
                ST_OUT: begin
                    drop_d = i_wx_valid;
                    if (i_y_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy    = (state_q != ST_IDLE);
    assign o_y_valid = (state_q == ST_OUT);
    assign o_drop    = drop_q;

    for (genvar g = 0; g < DIM; g++) begin : g_lane
        acc_lane #(
            .NUM_BIT (NUM_BIT),
            .ACC_BIT (ACC_BIT)
        ) u_lane (
            .clk     (i_clk_acc),
            .rst     (i_rst_acc),
            .load    (lane_load),
            .add     (lane_add),
            .capture (lane_final),
            .bias    (i_bias_acc[g]),
            .wx      (i_wx_result[g]),
            .y       (o_y_result[g])
        );
    end

endmodule

// File: tb/tb_acc_act.sv
// Self-checking bench for acc_act (DIM=4, NUM_BIT=16, NUM_PASS=2); expectations follow ACC_RELU_EN.
module tb_acc_act;

    localparam int DIM      = 4;
    localparam int NUM_BIT  = 16;
    localparam int NUM_PASS = 2;

    typedef logic [DIM-1:0][NUM_BIT-1:0] vec_t;

    logic clk = 1'b0;
    logic rst, start, wx_valid, y_ready;
    logic busy, drop, y_valid;
    vec_t bias, wx, y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acc_act #(
        .DIM      (DIM),
        .NUM_BIT  (NUM_BIT),
        .FRAC     (8),
        .NUM_PASS (NUM_PASS)
    ) dut (
        .i_clk_acc   (clk),
        .i_rst_acc   (rst),
        .i_start_acc (start),
        .i_bias_acc  (bias),
        .i_wx_valid  (wx_valid),
        .i_wx_result (wx),
        .o_busy      (busy),
        .o_drop      (drop),
        .o_y_valid   (y_valid),
        .i_y_ready   (y_ready),
        .o_y_result  (y)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t splat(input logic [15:0] v);
        vec_t r;
        for (int i = 0; i < DIM; i++) r[i] = v;
        return r;
    endfunction

    // Reference: exact integer sum of bias and both passes, optional ReLU, then clamp to 16-bit signed.
    function automatic vec_t model(input vec_t b, input vec_t a0, input vec_t a1);
        vec_t r;
        for (int i = 0; i < DIM; i++) begin
            int s;
            s = int'($signed(b[i])) + int'($signed(a0[i])) + int'($signed(a1[i]));
`ifdef ACC_RELU_EN
            if (s < 0) s = 0;
`endif
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            r[i] = s[15:0];
        end
        return r;
    endfunction

    function automatic vec_t rand_vec(input int mode);
        vec_t r;
        for (int i = 0; i < DIM; i++) begin
            case (mode)
                0: r[i] = 16'($urandom);
                1: r[i] = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
                default: r[i] = 16'($urandom_range(0, 1023)) - 16'd512;
            endcase
        end
        return r;
    endfunction

    task automatic do_start(input vec_t b);
        start = 1'b1;
        bias  = b;
        tick();
        start = 1'b0;
        bias  = ~b;
    endtask

    task automatic do_strobe(input vec_t v);
        wx_valid = 1'b1;
        wx       = v;
        tick();
        wx_valid = 1'b0;
        wx       = '0;
    endtask

    // Full transaction ending in OUT with y checked; gap idle cycles precede each strobe.
    task automatic run(input string tag, input vec_t b, input vec_t a0, input vec_t a1, input int gap);
        do_start(b);
        check({tag, " busy"}, 64'(busy), 64'd1);
        repeat (gap) tick();
        do_strobe(a0);
        repeat (gap) tick();
        do_strobe(a1);
        check({tag, " final"}, 64'(y_valid), 64'd0);
        tick();
        check({tag, " valid"}, 64'(y_valid), 64'd1);
        check({tag, " y"}, 64'(y), 64'(model(b, a0, a1)));
    endtask

    task automatic transfer(input string tag);
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        check({tag, " xfer valid"}, 64'(y_valid), 64'd0);
        check({tag, " xfer busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        vec_t held;
        rst = 1'b1; start = 1'b0; wx_valid = 1'b0; y_ready = 1'b0;
        bias = '0; wx = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst busy", 64'(busy), 64'd0);
        check("rst drop", 64'(drop), 64'd0);
        check("rst valid", 64'(y_valid), 64'd0);
        check("rst y", 64'(y), 64'd0);

        // Unity inputs, then positive saturation with a stray strobe during FINAL.
        run("t1", '0, splat(16'd256), splat(16'd256), 0);
        check("t1 y512", 64'(y), 64'(splat(16'd512)));
        transfer("t1");
        do_start(splat(16'h7000));
        do_strobe(splat(16'h7000));
        do_strobe(splat(16'h7000));
        do_strobe(splat(16'h1234));
        check("t2 drop final", 64'(drop), 64'd1);
        check("t2 valid", 64'(y_valid), 64'd1);
        check("t2 y sat", 64'(y), 64'(splat(16'h7FFF)));
        transfer("t2");

        // Negative result: ReLU zero or linear -512.
        run("t3", splat(16'd256), splat(16'hFE00), splat(16'hFF00), 1);
`ifdef ACC_RELU_EN
        check("t3 relu", 64'(y), 64'd0);
`else
        check("t3 lin", 64'(y), 64'(splat(16'hFE00)));
`endif
        transfer("t3");

        // Backpressure holds output stable.
        run("t4", rand_vec(2), rand_vec(2), rand_vec(2), 0);
        held = y;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4 hold valid", 64'(y_valid), 64'd1);
            check("t4 hold busy", 64'(busy), 64'd1);
            check("t4 hold y", 64'(y), 64'(held));
        end
        transfer("t4");

        // Restart mid-accumulation discards the earlier partial.
        do_start('0);
        do_strobe(splat(16'd100));
        run("t5", '0, splat(16'd1), splat(16'd2), 0);
        check("t5 y3", 64'(y), 64'(splat(16'd3)));
        transfer("t5");
        do_strobe(splat(16'd7));
        check("t5 idle drop", 64'(drop), 64'd1);
        check("t5 idle busy", 64'(busy), 64'd0);
        tick();
        check("t5 drop pulse", 64'(drop), 64'd0);

        // Start and strobe together: strobe dropped, count restarts.
        start = 1'b1; bias = '0; wx_valid = 1'b1; wx = splat(16'd1000);
        tick();
        start = 1'b0; wx_valid = 1'b0;
        check("sw drop", 64'(drop), 64'd1);
        do_strobe(splat(16'd5));
        check("sw one pass", 64'(y_valid), 64'd0);
        do_strobe(splat(16'd6));
        tick();
        check("sw valid", 64'(y_valid), 64'd1);
        check("sw y", 64'(y), 64'(model('0, splat(16'd5), splat(16'd6))));

        // Start and transfer in the same OUT cycle.
        start = 1'b1; bias = splat(16'd10); y_ready = 1'b1;
        tick();
        start = 1'b0; y_ready = 1'b0;
        check("st valid", 64'(y_valid), 64'd0);
        check("st busy", 64'(busy), 64'd1);
        do_strobe(splat(16'd20));
        do_strobe(splat(16'hFFFF));
        tick();
        check("st y", 64'(y), 64'(model(splat(16'd10), splat(16'd20), splat(16'hFFFF))));

        // Reset while in OUT.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6 valid", 64'(y_valid), 64'd0);
        check("t6 busy", 64'(busy), 64'd0);
        check("t6 y", 64'(y), 64'd0);

        for (int k = 0; k < 24; k++) begin
            int gap;
            vec_t b, a0, a1;
            b   = rand_vec(k % 3);
            a0  = rand_vec((k + 1) % 3);
            a1  = rand_vec(k % 3);
            gap = int'($urandom_range(0, 2));
            run("rnd", b, a0, a1, gap);
            repeat ($urandom_range(0, 3)) tick();
            check("rnd stall", 64'(y_valid), 64'd1);
            transfer("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

endmodule
